// File: rtl/trace_arbiter.sv
// Multi-core instruction-trace arbiter: per-core commit-record FIFOs drained
// round-robin into one registered output stage feeding a single tracer.
module trace_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int ARCH_LEN     = 32,
  parameter int NUM_WARPS    = 8,
  parameter int NUM_LANES    = 16,
  parameter int REG_BITS     = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int WARP_ID_BITS = $clog2(NUM_WARPS),
  parameter int CNT_BITS     = $clog2(FIFO_DEPTH) + 1,
  parameter int CORE_ID_BITS = $clog2(NUM_CORES)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_CORES-1:0]                  in_valid,
  output logic [NUM_CORES-1:0]                  in_ready,
  input  logic [NUM_CORES*ARCH_LEN-1:0]         in_pc,
  input  logic [NUM_CORES*WARP_ID_BITS-1:0]     in_warpId,
  input  logic [NUM_CORES*NUM_LANES-1:0]        in_tmask,
  input  logic [NUM_CORES-1:0]                  in_rd_enable,
  input  logic [NUM_CORES*REG_BITS-1:0]         in_rd_address,
  input  logic [NUM_CORES*NUM_LANES*ARCH_LEN-1:0] in_rd_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CORE_ID_BITS-1:0]               out_core_id,
  output logic [ARCH_LEN-1:0]                   out_pc,
  output logic [WARP_ID_BITS-1:0]               out_warpId,
  output logic [NUM_LANES-1:0]                  out_tmask,
  output logic                                  out_rd_enable,
  output logic [REG_BITS-1:0]                   out_rd_address,
  output logic [NUM_LANES*ARCH_LEN-1:0]         out_rd_data,
  input  logic                                  stat_clear,
  output logic [31:0]                           stall_cycles
);

  localparam int PTR_BITS = CNT_BITS - 1;
  localparam int DATA_W   = NUM_LANES * ARCH_LEN;
  localparam int REC_W    = ARCH_LEN + WARP_ID_BITS + NUM_LANES + 1 + REG_BITS + DATA_W;

  logic [REC_W-1:0]        in_rec [NUM_CORES];
  logic [REC_W-1:0]        head   [NUM_CORES];
  logic [NUM_CORES-1:0]    nonempty;
  logic [NUM_CORES-1:0]    push;
  logic [NUM_CORES-1:0]    pop;
  logic [CORE_ID_BITS-1:0] grant;
  logic [CORE_ID_BITS-1:0] rr_ptr;
  logic                    found;
  logic                    load_en;
  logic                    load;
  logic                    any_stall;
  logic [REC_W-1:0]        out_rec;
  int                      idx;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic [CNT_BITS-1:0] count;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [REC_W-1:0]    mem [FIFO_DEPTH];

    assign in_rec[g] = {in_pc[ARCH_LEN*g +: ARCH_LEN],
                        in_warpId[WARP_ID_BITS*g +: WARP_ID_BITS],
                        in_tmask[NUM_LANES*g +: NUM_LANES],
                        in_rd_enable[g],
                        in_rd_address[REG_BITS*g +: REG_BITS],
                        in_rd_data[DATA_W*g +: DATA_W]};

    // Ready depends only on this FIFO's count, so a full FIFO stays not-ready
    // even in the cycle it is popped.
    assign in_ready[g] = (count < CNT_BITS'(FIFO_DEPTH));
    assign nonempty[g] = (count != '0);
    assign push[g]     = in_valid[g] & in_ready[g];
    assign pop[g]      = load & (grant == CORE_ID_BITS'(g));
    assign head[g]     = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[g], pop[g]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (push[g]) mem[wr_ptr] <= in_rec[g];
    end
  end

  // First non-empty FIFO after the last granted core, wrapping.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CORES;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = CORE_ID_BITS'(idx);
      end
    end
  end

  assign load_en = !out_valid | out_ready;
  assign load    = load_en & found;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_core_id <= '0;
      out_rec     <= '0;
      rr_ptr      <= CORE_ID_BITS'(NUM_CORES - 1);
    end else if (load_en) begin
      out_valid <= found;
      if (found) begin
        out_core_id <= grant;
        out_rec     <= head[grant];
        rr_ptr      <= grant;
      end
    end
  end

  assign {out_pc, out_warpId, out_tmask, out_rd_enable, out_rd_address, out_rd_data} = out_rec;

  assign any_stall = |(in_valid & ~in_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (stat_clear) begin
      stall_cycles <= '0;
    end else if (any_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_trace_arbiter.sv
// Bench for trace_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_trace_arbiter;

  localparam int NC    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0]  pc;
    logic [2:0]   warp;
    logic [15:0]  tmask;
    logic         rd_en;
    logic [7:0]   rd_addr;
    logic [511:0] rd_data;
  } rec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] drv_valid = '0;
  rec_t          drv [NC];
  logic          out_ready = 1'b0;
  logic          stat_clear = 1'b0;

  logic [NC-1:0]      in_ready;
  logic [NC*32-1:0]   in_pc;
  logic [NC*3-1:0]    in_warpId;
  logic [NC*16-1:0]   in_tmask;
  logic [NC-1:0]      in_rd_enable;
  logic [NC*8-1:0]    in_rd_address;
  logic [NC*512-1:0]  in_rd_data;
  logic               out_valid;
  logic [1:0]         out_core_id;
  logic [31:0]        out_pc;
  logic [2:0]         out_warpId;
  logic [15:0]        out_tmask;
  logic               out_rd_enable;
  logic [7:0]         out_rd_address;
  logic [511:0]       out_rd_data;
  logic [31:0]        stall_cycles;
  rec_t               dut_rec;

  int n_tests = 0;
  int n_fail  = 0;

  rec_t        mq [NC][$];
  bit          m_ov;
  rec_t        m_out;
  int          m_core;
  int          m_rr;
  logic [31:0] m_stall;

  trace_arbiter dut (
    .clock(clock), .reset(reset),
    .in_valid(drv_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_warpId(in_warpId), .in_tmask(in_tmask),
    .in_rd_enable(in_rd_enable), .in_rd_address(in_rd_address), .in_rd_data(in_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_core_id(out_core_id),
    .out_pc(out_pc), .out_warpId(out_warpId), .out_tmask(out_tmask),
    .out_rd_enable(out_rd_enable), .out_rd_address(out_rd_address), .out_rd_data(out_rd_data),
    .stat_clear(stat_clear), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  always_comb begin
    in_pc = '0; in_warpId = '0; in_tmask = '0; in_rd_enable = '0;
    in_rd_address = '0; in_rd_data = '0;
    for (int i = 0; i < NC; i++) begin
      in_pc[32*i +: 32]         = drv[i].pc;
      in_warpId[3*i +: 3]       = drv[i].warp;
      in_tmask[16*i +: 16]      = drv[i].tmask;
      in_rd_enable[i]           = drv[i].rd_en;
      in_rd_address[8*i +: 8]   = drv[i].rd_addr;
      in_rd_data[512*i +: 512]  = drv[i].rd_data;
    end
  end

  assign dut_rec = {out_pc, out_warpId, out_tmask, out_rd_enable, out_rd_address, out_rd_data};

  function automatic rec_t rand_rec();
    rec_t r;
    r.pc      = $urandom;
    r.warp    = 3'($urandom);
    r.tmask   = 16'($urandom);
    r.rd_en   = 1'($urandom);
    r.rd_addr = 8'($urandom);
    for (int j = 0; j < 16; j++) r.rd_data[32*j +: 32] = $urandom;
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NC; i++) mq[i].delete();
    m_ov = 0; m_out = '0; m_core = 0; m_rr = NC - 1; m_stall = '0;
  endtask

  // Advance one clock edge, updating the reference model from the inputs
  // presented before the edge. acc reports which cores were accepted.
  task automatic tick(output logic [NC-1:0] acc);
    logic [NC-1:0] rdy;
    bit st;
    int g;
    for (int i = 0; i < NC; i++) rdy[i] = (mq[i].size() < DEPTH);
    st  = |(drv_valid & ~rdy);
    acc = drv_valid & rdy;
    if (!m_ov || out_ready) begin
      g = -1;
      for (int k = 1; k <= NC; k++) begin
        int c;
        c = (m_rr + k) % NC;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g >= 0) begin
        m_out = mq[g].pop_front(); m_core = g; m_rr = g; m_ov = 1;
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < NC; i++) if (acc[i]) mq[i].push_back(drv[i]);
    if (stat_clear) m_stall = '0;
    else if (st && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; drv_valid = '0; out_ready = 1'b0; stat_clear = 1'b0;
    m_clear();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (in_ready !== 4'hF) begin n_fail++; $display("FAIL reset_in_ready: got %h expected f", in_ready); end
    n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    n_tests++; if (out_core_id !== 2'd0) begin n_fail++; $display("FAIL reset_core_id: got %0d expected 0", out_core_id); end
    n_tests++; if (dut_rec !== rec_t'('0)) begin n_fail++; $display("FAIL reset_payload: got %h expected 0", dut_rec); end
  endtask

  task automatic test_single();
    rec_t r;
    logic [NC-1:0] a;
    do_reset();
    out_ready = 1'b1;
    r.pc = 32'h8000_0010; r.warp = 3'd3; r.tmask = 16'hFFFF; r.rd_en = 1'b1; r.rd_addr = 8'd5;
    for (int j = 0; j < 16; j++) r.rd_data[32*j +: 32] = 32'(j);
    drv[2] = r; drv_valid = 4'b0100;
    tick(a);
    drv_valid = '0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: out_valid got %b expected 0", out_valid); end
    tick(a);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_core_id !== 2'd2) begin n_fail++; $display("FAIL single_core: got %0d expected 2", out_core_id); end
    n_tests++; if (dut_rec !== r) begin n_fail++; $display("FAIL single_payload: got %h expected %h", dut_rec, r); end
    tick(a);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_simultaneous_refill();
    rec_t rs [NC];
    rec_t r1b;
    int   exp_c [5] = '{0, 1, 2, 3, 1};
    rec_t exp_r [5];
    logic [NC-1:0] a;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin rs[i] = rand_rec(); drv[i] = rs[i]; exp_r[i] = rs[i]; end
    r1b = rand_rec(); exp_r[4] = r1b;
    drv_valid = 4'hF;
    tick(a);
    drv_valid = '0;
    for (int s = 0; s < 5; s++) begin
      if (s == 2) begin drv[1] = r1b; drv_valid = 4'b0010; end
      tick(a);
      drv_valid = '0;
      n_tests++;
      if (out_valid !== 1'b1 || out_core_id !== 2'(exp_c[s]) || dut_rec !== exp_r[s]) begin
        n_fail++;
        $display("FAIL order_step%0d: got valid=%b core=%0d pc=%h expected valid=1 core=%0d pc=%h",
                 s, out_valid, out_core_id, out_pc, exp_c[s], exp_r[s].pc);
      end
    end
    tick(a);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_idle: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    rec_t rb [6];
    logic [NC-1:0] a;
    do_reset();
    for (int k = 0; k < 6; k++) rb[k] = rand_rec();
    for (int k = 0; k < 5; k++) begin
      drv[0] = rb[k]; drv_valid = 4'b0001;
      tick(a);
    end
    drv[0] = rb[5];
    n_tests++; if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready0 got %b expected 0", in_ready[0]); end
    n_tests++; if (out_valid !== 1'b1 || dut_rec !== rb[0]) begin n_fail++; $display("FAIL bp_head: valid=%b pc got %h expected %h", out_valid, out_pc, rb[0].pc); end
    for (int h = 1; h <= 3; h++) begin
      tick(a);
      n_tests++; if (stall_cycles !== 32'(h)) begin n_fail++; $display("FAIL bp_stall%0d: got %0d expected %0d", h, stall_cycles, h); end
      n_tests++; if (out_valid !== 1'b1 || dut_rec !== rb[0]) begin n_fail++; $display("FAIL bp_stable%0d: pc got %h expected %h", h, out_pc, rb[0].pc); end
      n_tests++; if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_held%0d: in_ready0 got %b expected 0", h, in_ready[0]); end
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(a);
      if (a[0]) drv_valid = '0;
      n_tests++;
      if (out_valid !== 1'b1 || out_core_id !== 2'd0 || dut_rec !== rb[k]) begin
        n_fail++;
        $display("FAIL bp_drain%0d: valid=%b core=%0d pc got %h expected %h", k, out_valid, out_core_id, out_pc, rb[k].pc);
      end
    end
    n_tests++; if (stall_cycles !== 32'd4) begin n_fail++; $display("FAIL bp_stall_total: got %0d expected 4", stall_cycles); end
    tick(a);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    rec_t n0, n3;
    logic [NC-1:0] a;
    do_reset();
    for (int i = 0; i < NC; i++) drv[i] = rand_rec();
    drv_valid = 4'hF;
    tick(a);
    drv_valid = '0;
    tick(a);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: out_valid got %b expected 1", out_valid); end
    #2 reset = 1'b0;
    m_clear();
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
    n_tests++; if (in_ready !== 4'hF) begin n_fail++; $display("FAIL rmid_ready: got %h expected f", in_ready); end
    n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rmid_stall: got %0d expected 0", stall_cycles); end
    #1 reset = 1'b1;
    n0 = rand_rec(); n3 = rand_rec();
    drv[0] = n0; drv[3] = n3; drv_valid = 4'b1001; out_ready = 1'b1;
    tick(a);
    drv_valid = '0;
    tick(a);
    n_tests++; if (out_valid !== 1'b1 || out_core_id !== 2'd0 || dut_rec !== n0) begin n_fail++; $display("FAIL rmid_first: valid=%b core=%0d pc got %h expected core 0 pc %h", out_valid, out_core_id, out_pc, n0.pc); end
    tick(a);
    n_tests++; if (out_valid !== 1'b1 || out_core_id !== 2'd3 || dut_rec !== n3) begin n_fail++; $display("FAIL rmid_second: valid=%b core=%0d pc got %h expected core 3 pc %h", out_valid, out_core_id, out_pc, n3.pc); end
  endtask

  task automatic test_stat_clear();
    logic [NC-1:0] a;
    do_reset();
    drv[0] = rand_rec(); drv_valid = 4'b0001;
    repeat (5) tick(a);
    n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL sc_start: got %0d expected 0", stall_cycles); end
    repeat (7) tick(a);
    n_tests++; if (stall_cycles !== 32'd7) begin n_fail++; $display("FAIL sc_accum: got %0d expected 7", stall_cycles); end
    stat_clear = 1'b1;
    tick(a);
    stat_clear = 1'b0;
    n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL sc_clear: got %0d expected 0", stall_cycles); end
    tick(a);
    n_tests++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL sc_resume1: got %0d expected 1", stall_cycles); end
    tick(a);
    n_tests++; if (stall_cycles !== 32'd2) begin n_fail++; $display("FAIL sc_resume2: got %0d expected 2", stall_cycles); end
    drv_valid = '0;
  endtask

  task automatic test_random();
    logic [NC-1:0] a;
    logic [NC-1:0] m_rdy;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < NC; i++)
        if (!drv_valid[i] && $urandom_range(0, 1) == 1) begin drv[i] = rand_rec(); drv_valid[i] = 1'b1; end
      out_ready  = ($urandom_range(0, 9) < 7);
      stat_clear = ($urandom_range(0, 19) == 0);
      tick(a);
      drv_valid  = drv_valid & ~a;
      stat_clear = 1'b0;
      for (int i = 0; i < NC; i++) m_rdy[i] = (mq[i].size() < DEPTH);
      n_tests++;
      if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, out_valid, m_ov); end
      if (m_ov) begin
        n_tests++;
        if (out_core_id !== 2'(m_core) || dut_rec !== m_out) begin
          n_fail++;
          $display("FAIL rnd_rec c%0d: core=%0d pc=%h expected core=%0d pc=%h", cyc, out_core_id, out_pc, m_core, m_out.pc);
        end
      end
      n_tests++; if (in_ready !== m_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %h expected %h", cyc, in_ready, m_rdy); end
      n_tests++; if (stall_cycles !== m_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d expected %0d", cyc, stall_cycles, m_stall); end
    end
    drv_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) drv[i] = '0;
    m_clear();
    test_reset();
    test_single();
    test_simultaneous_refill();
    test_backpressure();
    test_reset_mid();
    test_stat_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
